// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state, default widths and prefetch entry type for instr_fetch_unit
package ifu_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_STEP = 4;
  localparam int DEF_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} ifu_state_e;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fifo_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous show-ahead FIFO whose head word is held in a register
// Ports: clk, reset (async, active-high), push/din, pop, clear (drops all
// entries, wins over push/pop), dout (registered head), full, empty, count.
module ifu_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      dout <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      // head register follows whichever word becomes the new oldest entry
      if (do_push && (empty || (do_pop && count == CW'(1)))) dout <= din;
      else if (do_pop && count > CW'(1)) dout <= mem[rd_ptr + PW'(1)];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, fetch FSM and credit logic feeding a prefetch FIFO toward decode
// Ports: clk, reset (async, active-high), halt, redirect_valid/redirect_addr,
// RAM side mem_re/mem_addr/mem_rdata (1-cycle read), decode side
// if_valid/if_ready/if_instr/if_pc/if_pc_next.
// IFU_PERF_CNT_EN adds saturating perf_fetched, perf_redirects, perf_stall outputs.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic halt,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic if_valid,
  input  logic if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall,
`endif
  output logic [ADDR_W-1:0] if_pc_next
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  ifu_state_e state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, inflight_pc;
  logic inflight, redir, pop, push, full, empty;
  logic [CW-1:0] count;
  logic [ADDR_W+DATA_W-1:0] head;
  assign redir = redirect_valid && state != IDLE;
  assign pop = if_valid && if_ready;
  // a response arriving in a redirect cycle belongs to the abandoned path
  assign push = inflight && !redir && (!full || pop);
  assign mem_addr = pc;
  assign if_valid = !empty;
  assign {if_pc, if_instr} = head;
  assign if_pc_next = if_valid ? if_pc + STEP : '0;
  always_comb begin
    state_nx = state == IDLE ? RUN : redir ? FLUSH : halt ? HALTED : RUN;
    // credit counts the in-flight read so the FIFO can never overflow
    mem_re = state == RUN && !halt && !redirect_valid &&
             (count + CW'(inflight) - CW'(pop)) < CW'(FIFO_DEPTH);
    pc_nx = redir ? redirect_addr : mem_re ? pc + STEP : pc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= ADDR_W'(RESET_PC);
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      inflight <= mem_re;
      if (mem_re) inflight_pc <= pc;
    end
  ifu_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(redir),
    .din({inflight_pc, mem_rdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_fetched <= '0;
      perf_redirects <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (redir && !(&perf_redirects)) perf_redirects <= perf_redirects + 32'd1;
      if (state == RUN && !mem_re && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule
